id_ex_stage_register: RTL and testbench

//  ID/EX pipeline register of the 5-stage CPU. Sits directly downstream of the register file.

---
 rtl/id_ex_stage_register.sv | 226 ++++++++++++++++++++++
 tb/tb_id_ex_stage_register.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_register
// Description : ID/EX pipeline register of the 5-stage CPU. It captures the
//               register-file read data, the immediate, PC+4 and the decoded
//               control word at the end of ID. A writeback in the same cycle
//               is bypassed into the captured operands. Load-use hazards are
//               detected here, and a bubble is inserted into EX. The block
//               also supports an external hold (StallIn) and a branch flush
//               (FlushE).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RSTn                 clock; synchronous active-low reset
//   StallIn                   hold every EX output; no bypass, no count
//   FlushE                    squash the instruction entering EX
//   ValidD                    ID holds a real instruction
//   RsD, RtD, WriteRegD       source and destination register addresses
//   RD1D, RD2D                register file read data
//   ImmD, PCPlus4D            sign-extended immediate, PC+4
//   RegWriteD .. BranchD      decoded single-bit controls
//   ALUControlD               ALU operation
//   RegWriteW, WriteRegW,
//   ResultW                   WB-stage write port (bypass source)
//   *E outputs                registered EX-stage copies
//   LoadUseStall              combinational; IF and IF/ID hold when 1
//   BubbleCount               saturating count of load-use bubbles
// ============================================================================
module id_ex_stage_register #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 StallIn,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic [ADDR_W-1:0]    RsD,
    input  logic [ADDR_W-1:0]    RtD,
    input  logic [ADDR_W-1:0]    WriteRegD,
    input  logic [DATA_W-1:0]    RD1D,
    input  logic [DATA_W-1:0]    RD2D,
    input  logic [DATA_W-1:0]    ImmD,
    input  logic [DATA_W-1:0]    PCPlus4D,
    input  logic                 RegWriteD,
    input  logic                 MemtoRegD,
    input  logic                 MemWriteD,
    input  logic                 ALUSrcD,
    input  logic                 BranchD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 RegWriteW,
    input  logic [ADDR_W-1:0]    WriteRegW,
    input  logic [DATA_W-1:0]    ResultW,
    output logic                 ValidE,
    output logic [DATA_W-1:0]    SrcAE,
    output logic [DATA_W-1:0]    SrcBE,
    output logic [DATA_W-1:0]    ImmE,
    output logic [DATA_W-1:0]    PCPlus4E,
    output logic [ADDR_W-1:0]    RsE,
    output logic [ADDR_W-1:0]    RtE,
    output logic [ADDR_W-1:0]    WriteRegE,
    output logic                 RegWriteE,
    output logic                 MemtoRegE,
    output logic                 MemWriteE,
    output logic                 ALUSrcE,
    output logic                 BranchE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 LoadUseStall,
    output logic [CNT_W-1:0]     BubbleCount
);

    localparam logic [ADDR_W-1:0] c_reg_zero = '0;
    localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // EX-stage state
    // ------------------------------------------------------------------
    logic                 r_valid_e;
    logic [DATA_W-1:0]    r_src_a_e;
    logic [DATA_W-1:0]    r_src_b_e;
    logic [DATA_W-1:0]    r_imm_e;
    logic [DATA_W-1:0]    r_pc_plus4_e;
    logic [ADDR_W-1:0]    r_rs_e;
    logic [ADDR_W-1:0]    r_rt_e;
    logic [ADDR_W-1:0]    r_write_reg_e;
    logic                 r_reg_write_e;
    logic                 r_mem_to_reg_e;
    logic                 r_mem_write_e;
    logic                 r_alu_src_e;
    logic                 r_branch_e;
    logic [ALUCTRL_W-1:0] r_alu_control_e;
    logic [CNT_W-1:0]     r_bubble_count;

    // ------------------------------------------------------------------
    // Load-use detection. Only a valid load in EX that writes a
    // non-zero register can create the hazard. The instruction in ID must
    // also be real, and it must read that register through either source
    // port.
    // ------------------------------------------------------------------
    logic w_load_in_ex;
    logic w_src_match;
    logic w_load_use;

    assign w_load_in_ex = r_valid_e & r_mem_to_reg_e & r_reg_write_e
                          & (r_write_reg_e != c_reg_zero);
    assign w_src_match  = (r_write_reg_e == RsD) | (r_write_reg_e == RtD);
    assign w_load_use   = w_load_in_ex & ValidD & w_src_match;

    // ------------------------------------------------------------------
    // Same-cycle writeback bypass. The register file is written at the
    // same edge that it is read here, so RD1D/RD2D still show the old
    // value. r0 is never forwarded because its read data is
    // hard-wired to zero.
    // ------------------------------------------------------------------
    logic              w_wb_active;
    logic              w_bypass_a;
    logic              w_bypass_b;
    logic [DATA_W-1:0] w_src_a_d;
    logic [DATA_W-1:0] w_src_b_d;

    assign w_wb_active = RegWriteW & (WriteRegW != c_reg_zero);
    assign w_bypass_a  = w_wb_active & (WriteRegW == RsD);
    assign w_bypass_b  = w_wb_active & (WriteRegW == RtD);
    assign w_src_a_d   = w_bypass_a ? ResultW : RD1D;
    assign w_src_b_d   = w_bypass_b ? ResultW : RD2D;

    // ------------------------------------------------------------------
    // Edge action, in priority order: flush, hold, load-use bubble, capture.
    // A flush always produces the bubble itself. For this reason, a
    // load-use hazard that coincides with a flush is not counted.
    // ------------------------------------------------------------------
    logic w_bubble;
    logic w_capture;
    logic w_count_en;
    logic w_cnt_sat;

    assign w_bubble   = FlushE | (~StallIn & w_load_use);
    assign w_capture  = ~FlushE & ~StallIn & ~w_load_use;
    assign w_cnt_sat  = &r_bubble_count;
    assign w_count_en = ~FlushE & ~StallIn & w_load_use & ~w_cnt_sat;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_valid_e       <= 1'b0;
            r_src_a_e       <= '0;
            r_src_b_e       <= '0;
            r_imm_e         <= '0;
            r_pc_plus4_e    <= '0;
            r_rs_e          <= '0;
            r_rt_e          <= '0;
            r_write_reg_e   <= '0;
            r_reg_write_e   <= 1'b0;
            r_mem_to_reg_e  <= 1'b0;
            r_mem_write_e   <= 1'b0;
            r_alu_src_e     <= 1'b0;
            r_branch_e      <= 1'b0;
            r_alu_control_e <= '0;
            r_bubble_count  <= '0;
        end else begin
            if (w_bubble) begin
                // A bubble clears everything so that no stale address can
                // trigger forwarding or hazard logic further down.
                r_valid_e       <= 1'b0;
                r_src_a_e       <= '0;
                r_src_b_e       <= '0;
                r_imm_e         <= '0;
                r_pc_plus4_e    <= '0;
                r_rs_e          <= '0;
                r_rt_e          <= '0;
                r_write_reg_e   <= '0;
                r_reg_write_e   <= 1'b0;
                r_mem_to_reg_e  <= 1'b0;
                r_mem_write_e   <= 1'b0;
                r_alu_src_e     <= 1'b0;
                r_branch_e      <= 1'b0;
                r_alu_control_e <= '0;
            end else if (w_capture) begin
                r_valid_e       <= ValidD;
                r_src_a_e       <= w_src_a_d;
                r_src_b_e       <= w_src_b_d;
                r_imm_e         <= ImmD;
                r_pc_plus4_e    <= PCPlus4D;
                r_rs_e          <= RsD;
                r_rt_e          <= RtD;
                r_write_reg_e   <= WriteRegD;
                // An invalid ID slot must not write state, so its
                // single-bit controls are forced low.
                r_reg_write_e   <= RegWriteD & ValidD;
                r_mem_to_reg_e  <= MemtoRegD & ValidD;
                r_mem_write_e   <= MemWriteD & ValidD;
                r_alu_src_e     <= ALUSrcD   & ValidD;
                r_branch_e      <= BranchD   & ValidD;
                r_alu_control_e <= ALUControlD;
            end
            // Otherwise StallIn is active: every register keeps its value.

            if (w_count_en) begin
                r_bubble_count <= r_bubble_count + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ValidE       = r_valid_e;
    assign SrcAE        = r_src_a_e;
    assign SrcBE        = r_src_b_e;
    assign ImmE         = r_imm_e;
    assign PCPlus4E     = r_pc_plus4_e;
    assign RsE          = r_rs_e;
    assign RtE          = r_rt_e;
    assign WriteRegE    = r_write_reg_e;
    assign RegWriteE    = r_reg_write_e;
    assign MemtoRegE    = r_mem_to_reg_e;
    assign MemWriteE    = r_mem_write_e;
    assign ALUSrcE      = r_alu_src_e;
    assign BranchE      = r_branch_e;
    assign ALUControlE  = r_alu_control_e;
    assign LoadUseStall = w_load_use;
    assign BubbleCount  = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_register
// Description : Self-checking bench for id_ex_stage_register. One instance
//               uses the default widths. A second instance uses CNT_W=2 so
//               that counter saturation is reachable. A reference model keeps
//               the expected EX contents and an unbounded bubble tally.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_register;

    logic        CLK;
    logic        RSTn;
    logic        StallIn, FlushE, ValidD;
    logic [4:0]  RsD, RtD, WriteRegD, WriteRegW;
    logic [31:0] RD1D, RD2D, ImmD, PCPlus4D, ResultW;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, BranchD, RegWriteW;
    logic [3:0]  ALUControlD;

    // default-width instance
    logic        ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, LoadUseStall;
    logic [31:0] SrcAE, SrcBE, ImmE, PCPlus4E;
    logic [4:0]  RsE, RtE, WriteRegE;
    logic [3:0]  ALUControlE;
    logic [15:0] BubbleCount;

    // CNT_W=2 instance
    logic        s_ValidE, s_RegWriteE, s_MemtoRegE, s_MemWriteE, s_ALUSrcE, s_BranchE, s_LoadUseStall;
    logic [31:0] s_SrcAE, s_SrcBE, s_ImmE, s_PCPlus4E;
    logic [4:0]  s_RsE, s_RtE, s_WriteRegE;
    logic [3:0]  s_ALUControlE;
    logic [1:0]  s_BubbleCount;

    id_ex_stage_register dut (
        .CLK(CLK), .RSTn(RSTn), .StallIn(StallIn), .FlushE(FlushE), .ValidD(ValidD),
        .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD), .RD1D(RD1D), .RD2D(RD2D),
        .ImmD(ImmD), .PCPlus4D(PCPlus4D), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ValidE(ValidE), .SrcAE(SrcAE), .SrcBE(SrcBE), .ImmE(ImmE), .PCPlus4E(PCPlus4E),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .LoadUseStall(LoadUseStall), .BubbleCount(BubbleCount)
    );

    id_ex_stage_register #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RSTn(RSTn), .StallIn(StallIn), .FlushE(FlushE), .ValidD(ValidD),
        .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD), .RD1D(RD1D), .RD2D(RD2D),
        .ImmD(ImmD), .PCPlus4D(PCPlus4D), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ValidE(s_ValidE), .SrcAE(s_SrcAE), .SrcBE(s_SrcBE), .ImmE(s_ImmE), .PCPlus4E(s_PCPlus4E),
        .RsE(s_RsE), .RtE(s_RtE), .WriteRegE(s_WriteRegE), .RegWriteE(s_RegWriteE),
        .MemtoRegE(s_MemtoRegE), .MemWriteE(s_MemWriteE), .ALUSrcE(s_ALUSrcE), .BranchE(s_BranchE),
        .ALUControlE(s_ALUControlE), .LoadUseStall(s_LoadUseStall), .BubbleCount(s_BubbleCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic        m_valid, m_rw, m_mtr, m_mw, m_as, m_br;
    logic [31:0] m_srca, m_srcb, m_imm, m_pc4;
    logic [4:0]  m_rs, m_rt, m_wr;
    logic [3:0]  m_alu;
    int          m_nbub;   // bubbles inserted since reset, unbounded

    wire [152:0] obs   = {ValidE, SrcAE, SrcBE, ImmE, PCPlus4E, RsE, RtE, WriteRegE,
                          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE, ALUControlE};
    wire [152:0] obs_s = {s_ValidE, s_SrcAE, s_SrcBE, s_ImmE, s_PCPlus4E, s_RsE, s_RtE, s_WriteRegE,
                          s_RegWriteE, s_MemtoRegE, s_MemWriteE, s_ALUSrcE, s_BranchE, s_ALUControlE};

    function automatic logic [152:0] exp_vec();
        return {m_valid, m_srca, m_srcb, m_imm, m_pc4, m_rs, m_rt, m_wr,
                m_rw, m_mtr, m_mw, m_as, m_br, m_alu};
    endfunction

    function automatic logic exp_lus();
        return m_valid && m_mtr && m_rw && (m_wr != 5'd0) && ValidD &&
               (m_wr == RsD || m_wr == RtD);
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m_nbub > 65535) ? 16'hFFFF : 16'(m_nbub);
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return (m_nbub > 3) ? 2'd3 : 2'(m_nbub);
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_srca = 0; m_srcb = 0; m_imm = 0; m_pc4 = 0;
        m_rs = 0; m_rt = 0; m_wr = 0;
        m_rw = 0; m_mtr = 0; m_mw = 0; m_as = 0; m_br = 0; m_alu = 0;
    endtask

    // Advance the model by the rules for the coming edge, then wait for
    // the edge and settle 1 time unit past it.
    task automatic tick();
        logic lus;
        lus = exp_lus();
        if (!RSTn) begin
            model_bubble();
            m_nbub = 0;
        end else if (FlushE) begin
            model_bubble();
        end else if (StallIn) begin
            // hold
        end else if (lus) begin
            model_bubble();
            m_nbub++;
        end else begin
            m_valid = ValidD;
            m_srca  = (RegWriteW && WriteRegW != 0 && WriteRegW == RsD) ? ResultW : RD1D;
            m_srcb  = (RegWriteW && WriteRegW != 0 && WriteRegW == RtD) ? ResultW : RD2D;
            m_imm   = ImmD;  m_pc4 = PCPlus4D;
            m_rs    = RsD;   m_rt  = RtD;  m_wr = WriteRegD;
            m_rw    = RegWriteD & ValidD;
            m_mtr   = MemtoRegD & ValidD;
            m_mw    = MemWriteD & ValidD;
            m_as    = ALUSrcD & ValidD;
            m_br    = BranchD & ValidD;
            m_alu   = ALUControlD;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet_inputs();
        StallIn = 0; FlushE = 0; ValidD = 0;
        RsD = 0; RtD = 0; WriteRegD = 0; WriteRegW = 0;
        RD1D = 0; RD2D = 0; ImmD = 0; PCPlus4D = 0; ResultW = 0;
        RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; ALUSrcD = 0; BranchD = 0;
        RegWriteW = 0; ALUControlD = 0;
    endtask

    task automatic rand_inputs(input bit ctl);
        ValidD = 1'($urandom); RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
        WriteRegD = 5'($urandom_range(0, 7)); WriteRegW = 5'($urandom_range(0, 7));
        RD1D = $urandom; RD2D = $urandom; ImmD = $urandom; PCPlus4D = $urandom; ResultW = $urandom;
        RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom); MemWriteD = 1'($urandom);
        ALUSrcD = 1'($urandom); BranchD = 1'($urandom); RegWriteW = 1'($urandom);
        ALUControlD = 4'($urandom);
        if (ctl) begin
            StallIn = ($urandom_range(0, 5) == 0);
            FlushE  = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Capture a valid load into EX that writes register rd.
    task automatic load_into_ex(input logic [4:0] rd);
        quiet_inputs();
        ValidD = 1; MemtoRegD = 1; RegWriteD = 1; WriteRegD = rd;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RSTn = 0;
        rand_inputs(1'b1);
        tick();
        rand_inputs(1'b1);
        tick();
        total++;
        if (obs !== 153'd0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        total++;
        if (BubbleCount !== 16'd0 || s_BubbleCount !== 2'd0) begin
            bad++; $display("FAIL reset_count: got %0d/%0d expected 0/0", BubbleCount, s_BubbleCount);
        end
        total++;
        if (LoadUseStall !== 1'b0) begin
            bad++; $display("FAIL reset_lus: got %b expected 0", LoadUseStall);
        end
        RSTn = 1;
        quiet_inputs();
    endtask

    task automatic test_capture();
        quiet_inputs();
        ValidD = 1; RsD = 3; RD1D = 32'h11; RtD = 4; RD2D = 32'h22;
        ImmD = 32'hFFFF_FFF0; RegWriteD = 1; PCPlus4D = 32'h104; WriteRegD = 9; ALUControlD = 4'h6;
        tick();
        total++;
        if (SrcAE !== 32'h11 || SrcBE !== 32'h22 || ImmE !== 32'hFFFF_FFF0 || ValidE !== 1'b1) begin
            bad++; $display("FAIL capture: srca=%h srcb=%h imm=%h valid=%b expected 11 22 fffffff0 1",
                            SrcAE, SrcBE, ImmE, ValidE);
        end
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL capture_all: got %h expected %h", obs, exp_vec());
        end
        // invalid ID slot: control bits forced low
        quiet_inputs();
        ValidD = 0; RegWriteD = 1; MemtoRegD = 1; MemWriteD = 1; ALUSrcD = 1; BranchD = 1;
        tick();
        total++;
        if ({ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE} !== 6'd0) begin
            bad++; $display("FAIL invalid_ctl: got %b expected 000000",
                            {ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, BranchE});
        end
    endtask

    task automatic test_bypass();
        quiet_inputs();
        ValidD = 1; RsD = 5; RD1D = 32'h1; RtD = 6; RD2D = 32'h2;
        RegWriteW = 1; WriteRegW = 5; ResultW = 32'hABCD;
        tick();
        total++;
        if (SrcAE !== 32'hABCD || SrcBE !== 32'h2) begin
            bad++; $display("FAIL bypass_a: srca=%h srcb=%h expected abcd 2", SrcAE, SrcBE);
        end
        WriteRegW = 0;
        tick();
        total++;
        if (SrcAE !== 32'h1) begin
            bad++; $display("FAIL bypass_wr0: srca=%h expected 1", SrcAE);
        end
        // r0 source with a writeback to r0: no forwarding
        RsD = 0; RtD = 0; RD1D = 32'h0; RD2D = 32'h0; WriteRegW = 0; RegWriteW = 1;
        tick();
        total++;
        if (SrcAE !== 32'h0 || SrcBE !== 32'h0) begin
            bad++; $display("FAIL bypass_r0: srca=%h srcb=%h expected 0 0", SrcAE, SrcBE);
        end
        // B port forwarding, write enable off blocks it
        RtD = 12; RD2D = 32'h5; WriteRegW = 12; RegWriteW = 1; ResultW = 32'hBEEF;
        tick();
        total++;
        if (SrcBE !== 32'hBEEF) begin
            bad++; $display("FAIL bypass_b: srcb=%h expected beef", SrcBE);
        end
        RegWriteW = 0;
        tick();
        total++;
        if (SrcBE !== 32'h5) begin
            bad++; $display("FAIL bypass_b_off: srcb=%h expected 5", SrcBE);
        end
    endtask

    task automatic test_load_use();
        int n0;
        n0 = m_nbub;
        load_into_ex(5'd7);
        quiet_inputs();
        ValidD = 1; RsD = 1; RtD = 7; WriteRegD = 8; RegWriteD = 1;
        #1;
        total++;
        if (LoadUseStall !== 1'b1) begin
            bad++; $display("FAIL lus_detect: got %b expected 1", LoadUseStall);
        end
        tick();
        total++;
        if (ValidE !== 1'b0 || BubbleCount !== 16'(n0 + 1)) begin
            bad++; $display("FAIL lus_bubble: valid=%b count=%0d expected 0 %0d", ValidE, BubbleCount, n0 + 1);
        end
        total++;
        if (LoadUseStall !== 1'b0) begin
            bad++; $display("FAIL lus_clear: got %b expected 0", LoadUseStall);
        end
        tick();
        total++;
        if (obs !== exp_vec() || ValidE !== 1'b1 || WriteRegE !== 5'd8) begin
            bad++; $display("FAIL lus_resume: got %h expected %h", obs, exp_vec());
        end
        // invalid ID instruction does not cause a stall
        load_into_ex(5'd7);
        quiet_inputs();
        ValidD = 0; RsD = 7;
        #1;
        total++;
        if (LoadUseStall !== 1'b0) begin
            bad++; $display("FAIL lus_invalid_d: got %b expected 0", LoadUseStall);
        end
        // load to r0 never stalls
        load_into_ex(5'd0);
        quiet_inputs();
        ValidD = 1; RsD = 0; RtD = 0;
        #1;
        total++;
        if (LoadUseStall !== 1'b0) begin
            bad++; $display("FAIL lus_r0: got %b expected 0", LoadUseStall);
        end
        tick();
    endtask

    task automatic test_priority();
        int n0;
        load_into_ex(5'd9);
        quiet_inputs();
        ValidD = 1; RsD = 9; FlushE = 1; StallIn = 1;
        n0 = m_nbub;
        tick();
        total++;
        if (ValidE !== 1'b0 || BubbleCount !== 16'(n0)) begin
            bad++; $display("FAIL flush_over_stall: valid=%b count=%0d expected 0 %0d", ValidE, BubbleCount, n0);
        end
        // real instruction then hold for 3 edges with changing inputs
        quiet_inputs();
        ValidD = 1; RsD = 2; RtD = 3; RD1D = 32'hCAFE; RD2D = 32'hF00D; ImmD = 32'h44;
        RegWriteD = 1; ALUSrcD = 1; WriteRegD = 10;
        tick();
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b0);
            StallIn = 1; FlushE = 0;
            tick();
            total++;
            if (obs !== exp_vec() || ValidE !== 1'b1 || SrcAE !== 32'hCAFE) begin
                bad++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        StallIn = 0;
        quiet_inputs();
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            load_into_ex(5'd11);
            quiet_inputs();
            ValidD = 1; RtD = 11;
            tick();
        end
        total++;
        if (s_BubbleCount !== 2'd3) begin
            bad++; $display("FAIL sat_count2: got %0d expected 3", s_BubbleCount);
        end
        total++;
        if (BubbleCount !== exp_cnt16() || m_nbub < 5) begin
            bad++; $display("FAIL sat_count16: got %0d expected %0d", BubbleCount, exp_cnt16());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            RSTn = ($urandom_range(0, 60) != 0);
            #1;
            total++;
            if (LoadUseStall !== exp_lus() || s_LoadUseStall !== exp_lus()) begin
                bad++; $display("FAIL rand_lus[%0d]: got %b/%b expected %b", i, LoadUseStall, s_LoadUseStall, exp_lus());
            end
            tick();
            total++;
            if (obs !== exp_vec() || obs_s !== exp_vec()) begin
                bad++; $display("FAIL rand_state[%0d]: got %h expected %h", i, obs, exp_vec());
            end
            total++;
            if (BubbleCount !== exp_cnt16() || s_BubbleCount !== exp_cnt2()) begin
                bad++; $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d/%0d",
                                i, BubbleCount, s_BubbleCount, exp_cnt16(), exp_cnt2());
            end
        end
        RSTn = 1;
    endtask

    initial begin
        m_nbub = 0;
        model_bubble();
        quiet_inputs();
        RSTn = 0;
        test_reset();
        test_capture();
        test_bypass();
        test_load_use();
        test_priority();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
